// File: rtl/serial_pkg.sv
// Shared types for the bit-serial adder sequencing controller.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SHIFT,
        FLUSH,
        DONE
    } state_t;

    // Bit counter width: enough to count 0..width-1, never narrower than one bit.
    function automatic int cnt_w(input int width);
        return ($clog2(width) > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Parallel request/response bus between a requester and the serial adder controller.
// Latency: n/a (wiring only).
// Backpressure: requester may only issue start while ready is high; no queueing.
// Signals: start/a/b from requester; ready/busy/done/sum/cout back to requester.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b,
        input  ready, busy, done, sum, cout
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, sum, cout
    );

endinterface

// File: rtl/serial_adder_ctrl.sv
// Sequences one external bit-serial adder: clears carry, streams a/b LSB-first, collects sum.
// Latency: start accepted at edge E gives done in the cycle after edge E+WIDTH+2.
// Backpressure: start is ignored unless ready (IDLE); one operation per WIDTH+4 cycles.
// Ports: CLK/RESET (sync, active-high); req = parallel request bus (slave side);
//        sa_reset/sa_x/sa_y drive the adder's RESET/X/Y, sa_z is the adder's Z.
module serial_adder_ctrl
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    serial_adder_ctrl_if.slave  req,
    output logic                sa_reset,
    output logic                sa_x,
    output logic                sa_y,
    input  logic                sa_z
);

    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [CW-1:0]    cnt;
    logic             clr_c;

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        req.ready = 1'b0;
        req.busy  = 1'b0;
        clr_c     = 1'b0;
        sa_x      = 1'b0;
        sa_y      = 1'b0;
        case (state)
            IDLE: begin
                req.ready = 1'b1;
                if (req.start) begin
                    state_nxt = CLR;
                end
            end
            CLR: begin
                req.busy  = 1'b1;
                clr_c     = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                req.busy = 1'b1;
                sa_x     = a_sr[0];
                sa_y     = b_sr[0];
                if (cnt == LAST) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                // Zero inputs so sa_z reflects the adder's carry alone.
                req.busy  = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign sa_reset = RESET | clr_c;

    // Operand/sum shift registers and the registered result outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            a_sr     <= '0;
            b_sr     <= '0;
            sum_sr   <= '0;
            cnt      <= '0;
            req.sum  <= '0;
            req.cout <= 1'b0;
            req.done <= 1'b0;
        end else begin
            req.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req.start) begin
                        a_sr   <= req.a;
                        b_sr   <= req.b;
                        sum_sr <= '0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    // Sum bits arrive LSB-first, so enter at the MSB and drift down;
                    // the second assignment overrides the MSB of the shifted value.
                    sum_sr            <= sum_sr >> 1;
                    sum_sr[WIDTH-1]   <= sa_z;
                    a_sr              <= a_sr >> 1;
                    b_sr              <= b_sr >> 1;
                    cnt               <= cnt + CW'(1);
                end
                FLUSH: begin
                    req.cout <= sa_z;
                    req.sum  <= sum_sr;
                    req.done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl with a behavioural bit-serial adder on each instance.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    serial_adder_ctrl_if #(.WIDTH(8)) bus ();
    serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

    logic sa_reset, sa_x, sa_y, sa_z, carry;
    logic sa_reset1, sa_x1, sa_y1, sa_z1, carry1;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .CLK      (clk),
        .RESET    (rst),
        .req      (bus),
        .sa_reset (sa_reset),
        .sa_x     (sa_x),
        .sa_y     (sa_y),
        .sa_z     (sa_z)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .CLK      (clk),
        .RESET    (rst),
        .req      (bus1),
        .sa_reset (sa_reset1),
        .sa_x     (sa_x1),
        .sa_y     (sa_y1),
        .sa_z     (sa_z1)
    );

    // Bit-serial adder models.
    assign sa_z  = sa_x ^ sa_y ^ carry;
    assign sa_z1 = sa_x1 ^ sa_y1 ^ carry1;
    always_ff @(posedge clk) begin
        carry  <= sa_reset  ? 1'b0 : ((sa_x & sa_y) | (sa_x & carry) | (sa_y & carry));
        carry1 <= sa_reset1 ? 1'b0 : ((sa_x1 & sa_y1) | (sa_x1 & carry1) | (sa_y1 & carry1));
    end

    int total = 0;
    int bad   = 0;
    logic [8:0] sbq[$];   // {cout, sum}

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag);
        logic [8:0] e;
        chk({tag, " pending"}, 32'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({tag, " sum"},  32'(bus.sum),  32'(e[7:0]));
            chk({tag, " cout"}, 32'(bus.cout), 32'(e[8]));
        end
    endtask

    // Call at a negedge with ready high; returns at the negedge after the accept edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit push);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        if (push) sbq.push_back({1'b0, a} + {1'b0, b});
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int k0, input int lat);
        int k = k0;
        while (bus.done !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        chk({tag, " latency"}, 32'(k), 32'(lat));
        check_result(tag);
        tick();
        chk({tag, " pulse"}, 32'(bus.done), 0);
    endtask

    initial begin
        int k;
        int d1;
        int d2;
        int rhigh;
        int ndone;

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        bus1.start = 1'b0;
        bus1.a     = '0;
        bus1.b     = '0;
        tick();
        tick();

        // Reset state.
        chk("rst ready",    32'(bus.ready),  1);
        chk("rst busy",     32'(bus.busy),   0);
        chk("rst done",     32'(bus.done),   0);
        chk("rst sum",      32'(bus.sum),    0);
        chk("rst cout",     32'(bus.cout),   0);
        chk("rst sa_reset", 32'(sa_reset),   1);
        chk("rst sa_x",     32'(sa_x),       0);
        chk("rst sa_y",     32'(sa_y),       0);
        chk("rst ready1",   32'(bus1.ready), 1);
        rst = 1'b0;
        tick();
        chk("idle sa_reset", 32'(sa_reset), 0);

        // 0x5A + 0x3C: latency, single-cycle carry clear, hidden intermediate sum.
        send(8'h5A, 8'h3C, 1'b1);
        chk("t1 ready low",    32'(bus.ready), 0);
        chk("t1 busy",         32'(bus.busy),  1);
        chk("t1 clr",          32'(sa_reset),  1);
        tick();
        chk("t1 clr once",     32'(sa_reset),  0);
        tick();
        chk("t1 bit1 x",       32'(sa_x), 1);
        chk("t1 bit1 y",       32'(sa_y), 0);
        tick();
        tick();
        tick();
        chk("t1 sum hidden",   32'(bus.sum), 0);
        wait_done("t1", 5, 10);
        chk("t1 idle ready",   32'(bus.ready), 1);

        // Overflow, then zero operands after a carry-out.
        send(8'hFF, 8'h01, 1'b1);
        wait_done("t2", 0, 10);
        send(8'h00, 8'h00, 1'b1);
        wait_done("t3", 0, 10);

        // start held high: back-to-back operations.
        bus.a     = 8'h80;
        bus.b     = 8'h80;
        bus.start = 1'b1;
        sbq.push_back(9'h100);
        tick();
        d1 = -1;
        d2 = -1;
        rhigh = 0;
        for (k = 0; k <= 30; k++) begin
            if (k <= 10 && bus.ready) rhigh++;
            if (bus.done === 1'b1) begin
                if (d1 < 0) begin
                    d1 = k;
                    check_result("hold1");
                end else begin
                    d2 = k;
                    check_result("hold2");
                    bus.start = 1'b0;
                    break;
                end
            end
            if (bus.ready && bus.start) sbq.push_back({1'b0, bus.a} + {1'b0, bus.b});
            tick();
        end
        chk("hold first done", 32'(d1), 10);
        chk("hold spacing",    32'(d2 - d1), 12);
        chk("hold ready low",  32'(rhigh), 0);
        tick();
        chk("hold end done",   32'(bus.done),  0);
        chk("hold end ready",  32'(bus.ready), 1);
        tick();

        // Request while busy is ignored.
        send(8'h0F, 8'h01, 1'b1);
        tick();
        tick();
        tick();
        chk("ign ready", 32'(bus.ready), 0);
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done("ign", 4, 10);
        tick();
        chk("ign no second", 32'(bus.busy), 0);

        // Reset in the 4th SHIFT cycle aborts the operation.
        send(8'h33, 8'h44, 1'b0);
        tick();
        tick();
        tick();
        tick();
        chk("abort busy before", 32'(bus.busy), 1);
        rst = 1'b1;
        tick();
        chk("abort ready", 32'(bus.ready), 1);
        chk("abort busy",  32'(bus.busy),  0);
        chk("abort sum",   32'(bus.sum),   0);
        chk("abort cout",  32'(bus.cout),  0);
        chk("abort done",  32'(bus.done),  0);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        chk("abort no done", 32'(ndone), 0);
        send(8'h01, 8'h01, 1'b1);
        wait_done("post", 0, 10);

        // WIDTH=1 instance.
        bus1.a     = 1'b1;
        bus1.b     = 1'b1;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        k = 0;
        while (bus1.done !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("w1 latency", 32'(k), 3);
        chk("w1 sum",     32'(bus1.sum),  0);
        chk("w1 cout",    32'(bus1.cout), 1);

        chk("queue empty", 32'(sbq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
